// File: rtl/rv32_pkg.sv
// rv32_pkg: definitions shared by the RV32I core slice.
//   - loader_state_t   : state encoding of the instruction-memory loader
//   - FRAME_HDR_BYTES  : number of length bytes at the head of a load frame
//   - BYTES_PER_WORD   : bytes per 32-bit instruction word
//   - IMEM_WORDS_DEFAULT : instruction memory depth in words; Insmem uses the same value
package rv32_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN0 = 3'd1,
    S_LEN1 = 3'd2,
    S_DATA = 3'd3,
    S_CSUM = 3'd4,
    S_DONE = 3'd5,
    S_ERR  = 3'd6
  } loader_state_t;

  localparam int FRAME_HDR_BYTES    = 2;
  localparam int BYTES_PER_WORD     = 4;
  localparam int IMEM_WORDS_DEFAULT = 256;

endpackage

// File: rtl/byte_packer.sv
// byte_packer: assembles little-endian 32-bit words from a byte stream.
// Ports:
//   clk, rst     : clock, asynchronous active-low reset
//   clear        : synchronous clear of lane counter and word register
//   byte_valid   : byte_data is consumed this cycle
//   byte_data    : incoming byte, placed at lane `lane` (lane 0 = bits 7:0)
//   word         : assembled word register
//   word_ready   : one-cycle pulse, high the cycle after the 4th byte lands
//   lane         : current lane (next byte position)
module byte_packer
  import rv32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_ready,
  output logic [1:0]  lane
);

  localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word       <= '0;
      word_ready <= 1'b0;
      lane       <= '0;
    end else begin
      word_ready <= 1'b0;
      if (clear) begin
        word <= '0;
        lane <= '0;
      end else if (byte_valid) begin
        word[{lane, 3'b000} +: 8] <= byte_data;
        lane                      <= lane + 2'd1;
        // The word register already holds all four bytes when this pulse is high.
        word_ready                <= (lane == LAST_LANE);
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: byte-serial program loader for the RV32I instruction memory.
// Frame: LEN_LO, LEN_HI, LEN x 4 payload bytes (little-endian words), CSUM
// where CSUM is the XOR of all payload bytes.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   start      : pulse that begins a load (honoured in IDLE, DONE, ERR)
//   rx_data    : frame byte
//   rx_valid   : rx_data valid
//   rx_ready   : loader accepts a byte this cycle
//   im_we      : instruction memory write strobe (one cycle per word)
//   im_addr    : word address of the write
//   im_wdata   : instruction word
//   core_hold  : core reset, low only once a good image is loaded
//   busy       : frame in progress
//   done       : last frame loaded with a good checksum
//   err        : last frame rejected
//   fsm_state  : current loader state, for observation
//
// Handshake: a byte transfers on a rising edge where rx_valid && rx_ready.
// rx_ready is a registered function of state only and is high throughout
// LEN0..CSUM, so the sender may stream at one byte per cycle; rx_valid while
// rx_ready is low is ignored.
module imem_loader
  import rv32_pkg::*;
#(
  parameter int IMEM_WORDS = IMEM_WORDS_DEFAULT,
  parameter int ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              core_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output loader_state_t     fsm_state
);

  localparam logic [16:0] MAX_LEN = 17'(IMEM_WORDS);

  loader_state_t state, state_next;
  logic [7:0]    len_lo;
  logic [15:0]   frame_len;
  logic [15:0]   word_cnt;
  logic [7:0]    csum;
  logic [1:0]    lane;
  logic          accept;
  logic          start_ok;
  logic          data_byte;
  logic          word_end;
  logic [15:0]   len_in;

  assign accept    = rx_valid && rx_ready;
  assign start_ok  = start && (state == S_IDLE || state == S_DONE || state == S_ERR);
  assign data_byte = accept && (state == S_DATA);
  assign word_end  = data_byte && (lane == 2'd3);
  assign len_in    = {rx_data, len_lo};
  assign fsm_state = state;

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_ok),
    .byte_valid (data_byte),
    .byte_data  (rx_data),
    .word       (im_wdata),
    .word_ready (im_we),
    .lane       (lane)
  );

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (start) state_next = S_LEN0;
      S_LEN0: if (accept) state_next = S_LEN1;
      S_LEN1: begin
        if (accept) begin
          if ({1'b0, len_in} > MAX_LEN) state_next = S_ERR;
          else if (len_in == 16'd0)     state_next = S_CSUM;
          else                          state_next = S_DATA;
        end
      end
      S_DATA: if (word_end && (word_cnt + 16'd1 == frame_len)) state_next = S_CSUM;
      S_CSUM: begin
        if (accept) state_next = (rx_data == csum) ? S_DONE : S_ERR;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with
  // the state register without any input-to-output path.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      rx_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      core_hold <= 1'b1;
      len_lo    <= '0;
      frame_len <= '0;
      word_cnt  <= '0;
      csum      <= '0;
      im_addr   <= '0;
    end else begin
      state     <= state_next;
      rx_ready  <= (state_next == S_LEN0) || (state_next == S_LEN1) ||
                   (state_next == S_DATA) || (state_next == S_CSUM);
      busy      <= (state_next == S_LEN0) || (state_next == S_LEN1) ||
                   (state_next == S_DATA) || (state_next == S_CSUM);
      done      <= (state_next == S_DONE);
      err       <= (state_next == S_ERR);
      core_hold <= (state_next != S_DONE);

      if (start_ok) begin
        word_cnt <= '0;
        csum     <= '0;
      end
      if (accept && state == S_LEN0) len_lo    <= rx_data;
      if (accept && state == S_LEN1) frame_len <= len_in;
      if (data_byte) csum <= csum ^ rx_data;
      if (word_end) begin
        im_addr  <= word_cnt[ADDR_W-1:0];
        word_cnt <= word_cnt + 16'd1;
      end
    end
  end

endmodule
